// File: rtl/matmul_host_sequencer.sv
// Host-side sequencer for the matrix-multiply engine: streams A/B rows into matrix
// memory, kicks the compute, then reads C rows back through a credit-limited output FIFO.
module matmul_host_sequencer #(
  parameter int DWIDTH    = 512,
  parameter int AWIDTH    = 7,
  parameter int NUM_ROWS  = 32,
  parameter int WR_LAT    = 2,
  parameter int RD_LAT    = 6,
  parameter int OUT_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_start,
  output logic              busy,
  output logic              job_done,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_data,
  output logic              enable_writing_to_mem,
  output logic              enable_reading_from_mem,
  output logic              we_a,
  output logic              we_b,
  output logic              we_c,
  output logic              start_mat_mul_0,
  output logic [AWIDTH-1:0] addr_pi,
  output logic [DWIDTH-1:0] data_pi,
  input  logic              done_mat_mul,
  input  logic [DWIDTH-1:0] data_from_out_mat
);
  localparam int CW = $clog2(OUT_DEPTH + 1);
  localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;

  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, WR_FLUSH, COMPUTE, UNLOAD, DRAIN} state_t;

  state_t                       state;
  logic [AWIDTH-1:0]            cnt;
  logic [WR_LAT-1:0]            wa_pipe, wb_pipe;
  logic [WR_LAT-1:0][DWIDTH-1:0] wd_pipe;
  logic [RD_LAT-1:0]            rd_vld;
  logic [CW-1:0]                inflight, occ;
  logic [PW-1:0]                wr_ptr, rd_ptr;
  logic [DWIDTH-1:0]            mem [OUT_DEPTH];
  logic                         beat, rd_issue, room, last_row, push, pop;

  assign in_ready                = (state == LOAD_A) || (state == LOAD_B);
  assign busy                    = (state != IDLE);
  assign enable_writing_to_mem   = (state == LOAD_A) || (state == LOAD_B) || (state == WR_FLUSH);
  assign start_mat_mul_0         = (state == COMPUTE);
  assign we_c                    = (state == COMPUTE);
  assign enable_reading_from_mem = (state == UNLOAD) || ((state == DRAIN) && (inflight != '0));

  assign beat     = in_valid && in_ready;
  // Credit check counts reads already in flight so the FIFO can never overflow.
  assign room     = ({1'b0, occ} + {1'b0, inflight}) < (CW+1)'(OUT_DEPTH);
  assign rd_issue = (state == UNLOAD) && room;
  assign last_row = (cnt == AWIDTH'(NUM_ROWS - 1));
  assign addr_pi  = (beat || rd_issue) ? cnt : '0;

  assign push      = rd_vld[RD_LAT-1];
  assign out_valid = (occ != '0);
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  assign we_a    = wa_pipe[WR_LAT-1];
  assign we_b    = wb_pipe[WR_LAT-1];
  assign data_pi = wd_pipe[WR_LAT-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      job_done <= 1'b0;
    end else begin
      job_done <= 1'b0;
      case (state)
        IDLE: if (cmd_start) begin
          state <= LOAD_A;
          cnt   <= '0;
        end
        LOAD_A, LOAD_B: if (beat) begin
          cnt <= last_row ? '0 : cnt + AWIDTH'(1);
          if (last_row) state <= (state == LOAD_A) ? LOAD_B : WR_FLUSH;
        end
        // Counter reused to time the flush so the last write strobe lands first.
        WR_FLUSH: if (cnt == AWIDTH'(WR_LAT - 1)) begin
          cnt   <= '0;
          state <= COMPUTE;
        end else begin
          cnt <= cnt + AWIDTH'(1);
        end
        COMPUTE: if (done_mat_mul) state <= UNLOAD;
        UNLOAD: if (rd_issue) begin
          cnt <= last_row ? '0 : cnt + AWIDTH'(1);
          if (last_row) state <= DRAIN;
        end
        DRAIN: if ((inflight == '0) && (occ == '0)) begin
          state    <= IDLE;
          job_done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wa_pipe <= '0;
      wb_pipe <= '0;
      wd_pipe <= '0;
    end else begin
      wa_pipe[0] <= beat && (state == LOAD_A);
      wb_pipe[0] <= beat && (state == LOAD_B);
      wd_pipe[0] <= beat ? in_data : '0;
      for (int i = 1; i < WR_LAT; i++) begin
        wa_pipe[i] <= wa_pipe[i-1];
        wb_pipe[i] <= wb_pipe[i-1];
        wd_pipe[i] <= wd_pipe[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_vld   <= '0;
      inflight <= '0;
      occ      <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      rd_vld[0] <= rd_issue;
      for (int i = 1; i < RD_LAT; i++) rd_vld[i] <= rd_vld[i-1];
      case ({rd_issue, push})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
      case ({push, pop})
        2'b10:   occ <= occ + CW'(1);
        2'b01:   occ <= occ - CW'(1);
        default: occ <= occ;
      endcase
      if (push) wr_ptr <= (wr_ptr == PW'(OUT_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      if (pop)  rd_ptr <= (rd_ptr == PW'(OUT_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_from_out_mat;
  end

endmodule

// File: tb/tb_matmul_host_sequencer.sv
// Directed bench for matmul_host_sequencer: load, compute, unload, backpressure, mid-job reset.
module tb_matmul_host_sequencer;
  localparam int DW = 512;
  localparam int AW = 7;

  logic          clk = 0, reset_n = 0;
  logic          cmd_start = 0, busy, job_done;
  logic          in_valid = 0, in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid, out_ready = 1;
  logic [DW-1:0] out_data;
  logic          enable_writing_to_mem, enable_reading_from_mem;
  logic          we_a, we_b, we_c, start_mat_mul_0;
  logic [AW-1:0] addr_pi;
  logic [DW-1:0] data_pi;
  logic          done_mat_mul = 0;
  logic [DW-1:0] data_from_out_mat;
  logic [AW-1:0] ahist [6];

  int n_cmp = 0, n_err = 0;

  matmul_host_sequencer dut (
    .clk(clk), .reset_n(reset_n), .cmd_start(cmd_start), .busy(busy), .job_done(job_done),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .enable_writing_to_mem(enable_writing_to_mem), .enable_reading_from_mem(enable_reading_from_mem),
    .we_a(we_a), .we_b(we_b), .we_c(we_c), .start_mat_mul_0(start_mat_mul_0),
    .addr_pi(addr_pi), .data_pi(data_pi), .done_mat_mul(done_mat_mul),
    .data_from_out_mat(data_from_out_mat)
  );

  always #5 clk = ~clk;

  // Memory model: returns addr+0x100 for the address presented 6 cycles earlier.
  always @(posedge clk) begin
    ahist[0] <= addr_pi;
    for (int i = 1; i < 6; i++) ahist[i] <= ahist[i-1];
  end
  assign data_from_out_mat = DW'(ahist[5]) + DW'(256);

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if ({in_ready, out_valid, busy, job_done, we_a, we_b, we_c, enable_writing_to_mem,
         enable_reading_from_mem, start_mat_mul_0} !== 10'b0) begin
      n_err++; $display("FAIL reset_ctrl: got %b want 0", {in_ready, out_valid, busy, job_done,
        we_a, we_b, we_c, enable_writing_to_mem, enable_reading_from_mem, start_mat_mul_0});
    end
    n_cmp++;
    if (addr_pi !== '0 || data_pi !== '0 || out_data !== '0) begin
      n_err++; $display("FAIL reset_data: addr=%0h data_pi nonzero=%0b want 0", addr_pi, data_pi != '0);
    end
    @(negedge clk); reset_n = 1;
    @(negedge clk); #1;
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
  endtask

  // Streams 64 rows; gap=1 inserts idle cycles and strobes done_mat_mul in them.
  task automatic load_job(input bit gap);
    bit hv [300];
    int hb [300];
    int b = 0, last_n = -1;
    bit ea, eb, ew;
    logic [DW-1:0] ed;
    @(negedge clk); cmd_start = 1; #1;
    n_cmp++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      n_err++; $display("FAIL load_idle: busy=%b in_ready=%b want 0 0", busy, in_ready);
    end
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      cmd_start    = (n == 5);
      hv[n]        = (b < 64) && (!gap || (n % 2 == 0));
      hb[n]        = b;
      in_valid     = hv[n];
      in_data      = DW'(b) | (DW'(b) << 480);
      done_mat_mul = gap && !hv[n] && (b < 64);
      #1;
      if (n == 0) begin
        n_cmp++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL load_busy: got %b want 1", busy); end
      end
      if (b < 64) begin
        n_cmp++;
        if (in_ready !== 1'b1 || addr_pi !== (hv[n] ? AW'(b % 32) : AW'(0))) begin
          n_err++; $display("FAIL load_addr: n=%0d in_ready=%b addr=%0d want 1 %0d", n, in_ready,
                            addr_pi, hv[n] ? b % 32 : 0);
        end
      end
      if (n >= 2) begin
        ea = hv[n-2] && (hb[n-2] < 32);
        eb = hv[n-2] && (hb[n-2] >= 32);
        ed = hv[n-2] ? (DW'(hb[n-2]) | (DW'(hb[n-2]) << 480)) : '0;
        n_cmp++;
        if (we_a !== ea || we_b !== eb || data_pi !== ed) begin
          n_err++; $display("FAIL load_write: n=%0d we_a=%b we_b=%b data=%0h want %b %b %0h", n,
                            we_a, we_b, data_pi[7:0], ea, eb, ed[7:0]);
        end
      end
      ew = (last_n < 0) || (n <= last_n + 2);
      n_cmp++;
      if (enable_writing_to_mem !== ew) begin
        n_err++; $display("FAIL load_wr_en: n=%0d got %b want %b", n, enable_writing_to_mem, ew);
      end
      if (hv[n]) begin
        if (b == 63) last_n = n;
        b++;
      end
      if (last_n >= 0 && n == last_n + 3) begin
        n_cmp++;
        if (start_mat_mul_0 !== 1'b1) begin
          n_err++; $display("FAIL load_to_compute: start=%b want 1", start_mat_mul_0);
        end
        break;
      end
    end
    in_valid = 0; done_mat_mul = 0; cmd_start = 0;
    if (last_n < 0) begin
      n_cmp++; n_err++; $display("FAIL load_timeout: beats=%0d want 64", b);
    end
  endtask

  task automatic test_load();
    load_job(1'b0);
  endtask

  task automatic test_gapped_load();
    load_job(1'b1);
  endtask

  // Entered on the first COMPUTE cycle; done raised on the 100th.
  task automatic test_compute();
    for (int c = 2; c <= 100; c++) begin
      @(negedge clk);
      done_mat_mul = (c == 100);
      #1;
      n_cmp++;
      if (start_mat_mul_0 !== 1'b1 || we_c !== 1'b1) begin
        n_err++; $display("FAIL compute_hold: c=%0d start=%b we_c=%b want 1 1", c, start_mat_mul_0, we_c);
      end
    end
    @(negedge clk); done_mat_mul = 0; #1;
    n_cmp++;
    if (start_mat_mul_0 !== 1'b0 || we_c !== 1'b0 || enable_reading_from_mem !== 1'b1) begin
      n_err++; $display("FAIL compute_exit: start=%b we_c=%b rd_en=%b want 0 0 1",
                        start_mat_mul_0, we_c, enable_reading_from_mem);
    end
  endtask

  task automatic unload_job(input bit bp);
    int idx = 0, dones = 0, done_i = -1, mx = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      out_ready = !(bp && i < 50);
      #1;
      if (bp && i < 50 && enable_reading_from_mem && int'(addr_pi) > mx) mx = int'(addr_pi);
      if (bp && i == 49) begin
        n_cmp++;
        if (mx != 7 || out_valid !== 1'b1) begin
          n_err++; $display("FAIL bp_outstanding: max_addr=%0d out_valid=%b want 7 1", mx, out_valid);
        end
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (out_data !== DW'(256 + idx)) begin
          n_err++; $display("FAIL unload_data: idx=%0d got %0h want %0h", idx, out_data[15:0], 256 + idx);
        end
        idx++;
      end
      if (job_done === 1'b1) begin
        dones++;
        if (done_i < 0) done_i = i;
      end
      if (done_i >= 0 && i == done_i + 3) break;
    end
    out_ready = 1;
    n_cmp++;
    if (idx != 32 || dones != 1) begin
      n_err++; $display("FAIL unload_count: rows=%0d job_done=%0d want 32 1", idx, dones);
    end
    n_cmp++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || enable_reading_from_mem !== 1'b0) begin
      n_err++; $display("FAIL unload_idle: busy=%b out_valid=%b rd_en=%b want 0 0 0",
                        busy, out_valid, enable_reading_from_mem);
    end
  endtask

  task automatic test_unload();
    unload_job(1'b0);
  endtask

  task automatic test_backpressure();
    unload_job(1'b1);
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    @(negedge clk); cmd_start = 1;
    for (int b = 0; b <= 42; b++) begin
      @(negedge clk);
      cmd_start = 0; in_valid = 1; in_data = DW'(b);
    end
    #1;
    n_cmp++;
    if (addr_pi !== AW'(10) || we_b !== 1'b1) begin
      n_err++; $display("FAIL mid_pre: addr=%0d we_b=%b want 10 1", addr_pi, we_b);
    end
    #1 reset_n = 0;
    #1;
    n_cmp++;
    if ({in_ready, busy, job_done, we_a, we_b, enable_writing_to_mem} !== 6'b0 ||
        addr_pi !== '0 || data_pi !== '0) begin
      n_err++; $display("FAIL mid_reset: ctrl=%b addr=%0d want 0 0",
                        {in_ready, busy, job_done, we_a, we_b, enable_writing_to_mem}, addr_pi);
    end
    @(negedge clk); in_valid = 0; reset_n = 1;
    repeat (3) begin
      @(negedge clk); #1;
      if (job_done === 1'b1) dones++;
    end
    n_cmp++;
    if (dones != 0 || busy !== 1'b0) begin
      n_err++; $display("FAIL mid_abort: job_done=%0d busy=%b want 0 0", dones, busy);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_compute();
    test_unload();
    test_gapped_load();
    test_compute();
    test_backpressure();
    test_reset_mid();
    test_load();
    test_compute();
    test_unload();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/matmul_host_sequencer.md
MATMUL_HOST_SEQUENCER -- requirements
Module: matmul_host_sequencer

Interface
REQ-001 SHALL have parameter DWIDTH, default 512, meaning width of one matrix row word (32 elements x 16 bits).
REQ-002 SHALL have parameter AWIDTH, default 7, meaning matrix memory address width.
REQ-003 SHALL have parameter NUM_ROWS, default 32, meaning rows per A load, B load and C unload.
REQ-004 SHALL have parameter WR_LAT, default 2, meaning cycles from addr_pi to the memory address pins.
REQ-005 SHALL have parameter RD_LAT, default 6, meaning cycles from addr_pi to valid data_from_out_mat.
REQ-006 SHALL have parameter OUT_DEPTH, default 8, meaning output FIFO entries, with OUT_DEPTH >= RD_LAT+1.
REQ-007 SHALL have port clk, input, 1 bit: the single clock; all logic on rising edge.
REQ-008 SHALL have port reset_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-009 SHALL have ports cmd_start in 1, busy out 1, job_done out 1 (one-cycle pulse).
REQ-010 SHALL have ports in_valid in 1, in_ready out 1, in_data in DWIDTH: row stream, A rows then B rows.
REQ-011 SHALL have ports out_valid out 1, out_ready in 1, out_data out DWIDTH: C row stream.
REQ-012 SHALL have ports enable_writing_to_mem, enable_reading_from_mem, we_a, we_b, we_c, start_mat_mul_0, all out 1.
REQ-013 SHALL have ports addr_pi out AWIDTH, data_pi out DWIDTH, done_mat_mul in 1, data_from_out_mat in DWIDTH.

Function
REQ-014 SHALL implement states IDLE, LOAD_A, LOAD_B, WR_FLUSH, COMPUTE, UNLOAD, DRAIN.
REQ-015 IDLE: cmd_start=1 -> LOAD_A, row counter cleared, busy=1 from next cycle; cmd_start ignored when not IDLE.
REQ-016 LOAD_A/LOAD_B: in_ready=1 in these states only; each in_valid&in_ready beat issues addr_pi=row counter, counter+1.
REQ-017 Write pipeline: data_pi and we_a (LOAD_A) / we_b (LOAD_B) SHALL appear exactly WR_LAT cycles after the addr_pi of the same beat; we_* low on all other cycles.
REQ-018 Counter reaching NUM_ROWS-1 on a beat: LOAD_A -> LOAD_B (counter cleared), LOAD_B -> WR_FLUSH.
REQ-019 enable_writing_to_mem SHALL be high from LOAD_A entry until the final write strobe has completed.
REQ-020 WR_FLUSH SHALL last WR_LAT cycles, then enter COMPUTE.
REQ-021 COMPUTE: start_mat_mul_0=1 and we_c=1 held every cycle until done_mat_mul=1 is sampled; next cycle both low, state UNLOAD.
REQ-022 UNLOAD: enable_reading_from_mem=1; a read issues (addr_pi=counter, counter+1) only when FIFO occupancy + reads in flight < OUT_DEPTH.
REQ-023 Read tracking: RD_LAT-deep valid shift register; data_from_out_mat SHALL be pushed into the FIFO exactly RD_LAT cycles after its addr_pi.
REQ-024 After NUM_ROWS reads: -> DRAIN; enable_reading_from_mem stays high until the last in-flight read returns.
REQ-025 DRAIN -> IDLE when no reads are in flight and the FIFO is empty; job_done pulses 1 cycle on that transition; busy=0 in IDLE.
REQ-026 Output FIFO: out_valid = not empty; pop on out_valid&out_ready; simultaneous push and pop at full or empty SHALL be lossless; overflow impossible by REQ-022.
REQ-027 Counters SHALL be AWIDTH bits and never exceed NUM_ROWS-1; addr_pi held 0 when not issuing.
REQ-028 done_mat_mul asserted outside COMPUTE SHALL be ignored.

Reset
REQ-029 reset_n=0 SHALL asynchronously force IDLE; clear counters, FIFO and in-flight shift register; drive all outputs 0, including in_ready, out_valid, busy, job_done, we_*, enables, start_mat_mul_0, addr_pi and data_pi.
REQ-030 Reset mid-job SHALL abort the job without job_done; the next cmd_start SHALL begin a fresh job at LOAD_A row 0.

Verification
REQ-031 Load: cmd_start, 64 back-to-back beats with in_data=row index -> addr_pi 0..31 twice; we_a 32 cycles, then we_b 32 cycles, each lagging addr_pi by 2; data_pi matches.
REQ-032 Gapped input: in_valid toggling 1/0 -> no write without a beat; addresses stay contiguous.
REQ-033 Compute: done_mat_mul raised 100 cycles after COMPUTE entry -> start_mat_mul_0 and we_c high for exactly those cycles, then UNLOAD.
REQ-034 Unload with memory model returning addr+0x100 at latency 6 and out_ready=1 -> 32 rows 0x100..0x11F in order, then job_done once.
REQ-035 Backpressure: out_ready=0 for 50 cycles during UNLOAD -> reads stop at 8 outstanding plus stored; no loss or duplication after release.
REQ-036 reset_n pulsed low during LOAD_B row 10 -> all outputs 0 immediately; new job loads A from row 0.
